// File: rtl/regfile.sv
// rtl/regfile.sv - 32x32 integer register file, two combinational reads, one synchronous write
// Optional macro REGFILE_X0_ZERO_EN: hardwire x0 to zero (writes to x0 ignored, reads of x0 return 0).
module regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rd_addr,
  input  logic        rd_wren,
  input  logic [31:0] rd_data,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data
);

  logic [31:0] register_array [0:31];
  logic        wr_en;

`ifdef REGFILE_X0_ZERO_EN
  assign wr_en    = rd_wren && (rd_addr != 5'd0);
  assign rs1_data = (rs1_addr == 5'd0) ? 32'h0 : register_array[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? 32'h0 : register_array[rs2_addr];
`else
  assign wr_en    = rd_wren;
  assign rs1_data = register_array[rs1_addr];
  assign rs2_data = register_array[rs2_addr];
`endif

  // No bypass: a read of rd_addr sees the old word until the write edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        register_array[i] <= 32'h0;
      end
    end else if (wr_en) begin
      register_array[rd_addr] <= rd_data;
    end
  end

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - scoreboard bench for regfile (run with and without REGFILE_X0_ZERO_EN)
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [4:0]  rd_addr = '0;
  logic        rd_wren = 1'b0;
  logic [31:0] rd_data = '0;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [0:31];
  logic [31:0] sbq [$];

  regfile dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rd_addr  (rd_addr),
    .rd_wren  (rd_wren),
    .rd_data  (rd_data),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  task automatic model_write(input logic [4:0] a, input logic [31:0] d);
`ifdef REGFILE_X0_ZERO_EN
    if (a != 5'd0) model[a] = d;
`else
    model[a] = d;
`endif
  endtask

  // Drive one write cycle; called #1 after a rising edge.
  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic en);
    rd_addr = a;
    rd_data = d;
    rd_wren = en;
    @(posedge clk);
    #1;
    if (en) model_write(a, d);
    rd_wren = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2, input string tag);
    rs1_addr = a1;
    rs2_addr = a2;
    sbq.push_back(model[a1]);
    sbq.push_back(model[a2]);
    #1;
    check({tag, "_rs1"}, rs1_data, sbq.pop_front());
    check({tag, "_rs2"}, rs2_data, sbq.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0]  a;
    logic [31:0] d;
    model_clear();

    // Reset, held one cycle, then sweep every address on both ports
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 32; i++) rd(i[4:0], 5'(31 - i), "reset");

    // Random write/readback through the storage array
    for (int n = 0; n < 100; n++) begin
      a = 5'($urandom_range(1, 31));
      d = $urandom;
      wr(a, d, 1'b1);
      sbq.push_back(d);
      check("wr_array", dut.register_array[a], sbq.pop_front());
    end
    for (int n = 0; n < 100; n++) rd(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "rand_rd");

    // Write-enable gating
    wr(5'd5, 32'hDEADBEEF, 1'b1);
    wr(5'd5, 32'h12345678, 1'b0);
    rd(5'd5, 5'd5, "wren_gate");

    // Same-cycle read/write: old value before the edge, new value after
    wr(5'd7, 32'h1, 1'b1);
    rd_addr = 5'd7;
    rd_data = 32'h2;
    rd_wren = 1'b1;
    rd(5'd7, 5'd7, "rw_pre");
    @(posedge clk);
    #1;
    model_write(5'd7, 32'h2);
    rd_wren = 1'b0;
    rd(5'd7, 5'd7, "rw_post");

    // Back-to-back writes, last wins
    wr(5'd12, 32'hAAAA0001, 1'b1);
    wr(5'd12, 32'hBBBB0002, 1'b1);
    rd(5'd12, 5'd12, "b2b");

    // x0 behaviour
    wr(5'd0, 32'hFFFFFFFF, 1'b1);
    sbq.push_back(
`ifdef REGFILE_X0_ZERO_EN
      32'h0
`else
      32'hFFFFFFFF
`endif
    );
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    #1;
    check("x0_rs1", rs1_data, sbq[0]);
    check("x0_rs2", rs2_data, sbq.pop_front());

    // Async reset mid-run drops x3 before the next edge
    wr(5'd3, 32'hA5A5A5A5, 1'b1);
    rd(5'd3, 5'd3, "x3_set");
    #1 rst_n = 1'b0;
    model_clear();
    rd(5'd3, 5'd7, "async_rst");

    // Write presented while in reset is lost
    rd_addr = 5'd9;
    rd_data = 32'h00000011;
    rd_wren = 1'b1;
    @(posedge clk);
    #1;
    rd_wren = 1'b0;
    rd(5'd9, 5'd12, "wr_in_rst");

    // Release between edges; the write at the next edge is performed
    rst_n = 1'b1;
    wr(5'd9, 32'h00000077, 1'b1);
    rd(5'd9, 5'd3, "post_rst_wr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
